// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break from idle).
package mem_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  // Current bus owner; NONE means the next grant starts a fresh tenure.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  // Tenure counter increment that sticks at the top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision for the two-port memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break from idle).
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  owner_t           owner,
  input  logic [CNT_W-1:0] cnt,
  input  logic             last,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST);

  // Port that wins a simultaneous request while nobody owns the bus.
  logic tie_sel;
  logic burst_done;

`ifdef MEM_ARB_RR_EN
  assign tie_sel = ~last;
`else
  assign tie_sel = 1'b0;
  // last only steers ties in the round-robin build.
  logic unused_last;
  assign unused_last = last;
`endif

  assign burst_done = (cnt >= LIMIT);

  // Owner keeps the bus until its burst is spent while the other port waits,
  // or until it drops its request; a handover happens in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (owner)
      OWN_P0: begin
        if (req0 && (!burst_done || !req1)) gnt0 = 1'b1;
        else if (req1)                      gnt1 = 1'b1;
      end
      OWN_P1: begin
        if (req1 && (!burst_done || !req0)) gnt1 = 1'b1;
        else if (req0)                      gnt0 = 1'b1;
      end
      default: begin
        if (req0 && req1) begin
          gnt0 = ~tie_sel;
          gnt1 = tie_sel;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous memory between the
// processor data port (port 0) and the boot/debug loader (port 1).
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break from idle).
//
// Handshake: a requester raises req k with we/addr/wdata stable and holds them
// until gnt k is seen high in the same cycle; gnt k is the acceptance, the
// access goes to memory that cycle, and a read answers with rvalid k exactly
// one cycle later. Writes have no response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output owner_t            owner,
  output logic [CNT_W-1:0]  cnt
);

  logic last;
  logic pick_gnt0;
  logic pick_gnt1;

  mem_arb_pick #(
    .MAX_BURST(MAX_BURST)
  ) u_pick (
    .owner(owner),
    .cnt  (cnt),
    .last (last),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (pick_gnt0),
    .gnt1 (pick_gnt1)
  );

  // No access may leave the arbiter while reset is held.
  assign gnt0 = pick_gnt0 & ~reset;
  assign gnt1 = pick_gnt1 & ~reset;

  assign mem_en    = gnt0 | gnt1;
  assign mem_we    = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  assign rdata0 = rvalid0 ? mem_rdata : '0;
  assign rdata1 = rvalid1 ? mem_rdata : '0;

  // Ownership/tenure state and read-response flags, all advanced by the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= OWN_NONE;
      cnt     <= '0;
      last    <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0) begin
        last <= 1'b0;
        if (owner == OWN_P0) begin
          cnt <= sat_inc(cnt);
        end else begin
          owner <= OWN_P0;
          cnt   <= 4'd1;
        end
      end else if (gnt1) begin
        last <= 1'b1;
        if (owner == OWN_P1) begin
          cnt <= sat_inc(cnt);
        end else begin
          owner <= OWN_P1;
          cnt   <= 4'd1;
        end
      end else begin
        owner <= OWN_NONE;
        cnt   <= '0;
      end
    end
  end

endmodule
